ram_access_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the 256-word data RAM. Port 0 (instruction fetch) and

---
 rtl/ram_access_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_access_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-port arbiter/sequencer for the 256-word data RAM.
// Port 0 (instruction fetch) and port 1 (load/store) share one RAM; each access
// walks IDLE -> ACCESS -> DONE, so one access completes every three cycles.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate ownership on ties);
// when undefined, port 0 has fixed priority on ties.
module ram_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] adress,
    output logic              enram,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              owner, owner_next;
    logic              last_owner, last_owner_next;
    logic              pick;
    logic              gnt0_next, gnt1_next, rvalid0_next, rvalid1_next;
    logic              enram_next, ram_we_next, busy_next;
    logic [ADDR_W-1:0] adress_next;
    logic [DATA_W-1:0] ram_wdata_next, rdata_next;

    // Choose the winning port among the current requests (only meaningful when any req is high)
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick = (req0 && req1) ? ~last_owner : ~req0;
`else
        pick = ~req0;
`endif
    end

    // Next-state and registered-output decode; every output is a flop so the decoder sees clean edges
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_owner_next = last_owner;
        gnt0_next       = 1'b0;
        gnt1_next       = 1'b0;
        rvalid0_next    = 1'b0;
        rvalid1_next    = 1'b0;
        enram_next      = 1'b0;
        ram_we_next     = 1'b0;
        busy_next       = 1'b0;
        adress_next     = '0;
        ram_wdata_next  = ram_wdata;
        rdata_next      = rdata;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next     = ACCESS;
                    owner_next     = pick;
                    gnt0_next      = ~pick;
                    gnt1_next      = pick;
                    enram_next     = 1'b1;
                    busy_next      = 1'b1;
                    adress_next    = pick ? addr1  : addr0;
                    ram_we_next    = pick ? we1    : we0;
                    ram_wdata_next = pick ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                // ram_we still holds the owner's latched direction during this cycle
                state_next   = DONE;
                busy_next    = 1'b1;
                rvalid0_next = ~owner;
                rvalid1_next = owner;
                if (!ram_we) begin
                    rdata_next = ram_rdata;
                end
            end
            DONE: begin
                state_next      = IDLE;
                last_owner_next = owner;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything at once so an aborted write never completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            enram      <= 1'b0;
            ram_we     <= 1'b0;
            busy       <= 1'b0;
            adress     <= '0;
            ram_wdata  <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_owner <= last_owner_next;
            gnt0       <= gnt0_next;
            gnt1       <= gnt1_next;
            rvalid0    <= rvalid0_next;
            rvalid1    <= rvalid1_next;
            enram      <= enram_next;
            ram_we     <= ram_we_next;
            busy       <= busy_next;
            adress     <= adress_next;
            ram_wdata  <= ram_wdata_next;
            rdata      <= rdata_next;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: randomized requests on both ports checked against a
// transaction-level model (reference memory, pending-request table, tie rule).
module tb_ram_access_arbiter;

    logic       clk, reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1;
    logic [7:0] rdata, adress, ram_wdata, ram_rdata;
    logic       enram, ram_we, busy;

    ram_access_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .adress(adress), .enram(enram), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in RAM array: combinational read of the selected word, write at the clock edge
    logic [7:0] mem_ram [256];
    assign ram_rdata = mem_ram[adress];
    always @(posedge clk) begin
        if (enram && ram_we) mem_ram[adress] <= ram_wdata;
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    bit         pend [2];
    bit         pwe  [2];
    logic [7:0] paddr [2];
    logic [7:0] pwdata [2];
    bit         last_owner;
    logic [7:0] exp_rdata;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pick_owner(bit p0, bit p1, bit lo);
        if (p0 && p1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !lo;
`else
            return 1'b0;
`endif
        end
        return !p0;
    endfunction

    function automatic logic [7:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic drive_ports();
        req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pwdata[0];
        req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pwdata[1];
    endtask

    task automatic set_req(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
        pend[p] = 1'b1; pwe[p] = w; paddr[p] = a; pwdata[p] = d;
    endtask

    // One full access, starting from a negedge in IDLE with at least one pending request
    task automatic run_access();
        int         o;
        bit         w;
        logic [7:0] a, d;
        o = int'(pick_owner(pend[0], pend[1], last_owner));
        w = pwe[o]; a = paddr[o]; d = pwdata[o];
        drive_ports();
        @(posedge clk); @(negedge clk);
        // ACCESS
        check_val("acc_gnt0", 32'(gnt0), 32'(o == 0));
        check_val("acc_gnt1", 32'(gnt1), 32'(o == 1));
        check_val("acc_enram", 32'(enram), 32'd1);
        check_val("acc_adress", 32'(adress), 32'(a));
        check_val("acc_ram_we", 32'(ram_we), 32'(w));
        check_val("acc_busy", 32'(busy), 32'd1);
        if (w) check_val("acc_wdata", 32'(ram_wdata), 32'(d));
        // Owner perturbs its inputs mid-access while still holding req
        if (o == 0) begin addr0 = a ^ 8'h10; we0 = ~w; wdata0 = ~d; end
        else        begin addr1 = a ^ 8'h10; we1 = ~w; wdata1 = ~d; end
        #1;
        check_val("acc_adress_hold", 32'(adress), 32'(a));
        check_val("acc_we_hold", 32'(ram_we), 32'(w));
        @(posedge clk); @(negedge clk);
        // DONE
        if (!w) exp_rdata = ref_mem[a];
        else    ref_mem[a] = d;
        last_owner = (o == 1);
        check_val("done_rvalid0", 32'(rvalid0), 32'(o == 0));
        check_val("done_rvalid1", 32'(rvalid1), 32'(o == 1));
        check_val("done_gnt", 32'({gnt0, gnt1}), 32'd0);
        check_val("done_enram", 32'({enram, ram_we}), 32'd0);
        check_val("done_busy", 32'(busy), 32'd1);
        check_val("done_rdata", 32'(rdata), 32'(exp_rdata));
        pend[o] = 1'b0;
        drive_ports();
        @(posedge clk); @(negedge clk);
        // IDLE again
        check_val("idle_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_enram", 32'(enram), 32'd0);
        $display("access port%0d %s addr=0x%02h data=0x%02h rdata=0x%02h", o, w ? "WR" : "RD", a, d, rdata);
    endtask

    task automatic idle_cycle();
        drive_ports();
        @(posedge clk); @(negedge clk);
        check_val("noreq_busy", 32'(busy), 32'd0);
        check_val("noreq_enram", 32'(enram), 32'd0);
        check_val("noreq_adress", 32'(adress), 32'd0);
        check_val("noreq_gnt", 32'({gnt0, gnt1}), 32'd0);
        $display("idle cycle");
    endtask

    initial begin
        logic [7:0] v;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom_range(0, 255));
            mem_ram[i] = v;
            ref_mem[i] = v;
        end
        mem_ram[0] = 8'h5A;    ref_mem[0] = 8'h5A;
        mem_ram[8'h10] = 8'h11; ref_mem[8'h10] = 8'h11;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = 8'h00; pwdata[p] = 8'h00;
        end
        last_owner = 1'b1;
        exp_rdata  = 8'h00;
        drive_ports();
        repeat (2) @(negedge clk);
        // Reset state
        check_val("rst_outputs", 32'({gnt0, gnt1, rvalid0, rvalid1, enram, ram_we, busy}), 32'd0);
        check_val("rst_adress", 32'(adress), 32'd0);
        check_val("rst_rdata", 32'(rdata), 32'd0);
        check_val("rst_wdata", 32'(ram_wdata), 32'd0);
        reset = 1'b0;
        idle_cycle();

        // Read of word 0
        set_req(0, 1'b0, 8'h00, 8'h00);
        run_access();
        // Write then read of the top address from port 1
        set_req(1, 1'b1, 8'hFF, 8'hC3);
        run_access();
        set_req(1, 1'b0, 8'hFF, 8'h00);
        run_access();
        check_val("top_word_read", 32'(rdata), 32'hC3);
        // Address change during ACCESS (0x20 -> 0x30) must not affect the access
        set_req(0, 1'b0, 8'h20, 8'h00);
        run_access();

        // Reset during the ACCESS cycle of a write to 0x10
        set_req(0, 1'b1, 8'h10, 8'h99);
        drive_ports();
        @(posedge clk); @(negedge clk);
        check_val("abort_pre_enram", 32'(enram), 32'd1);
        reset = 1'b1;
        pend[0] = 1'b0;
        drive_ports();
        #1;
        check_val("abort_enram", 32'(enram), 32'd0);
        check_val("abort_ram_we", 32'(ram_we), 32'd0);
        check_val("abort_gnt", 32'({gnt0, gnt1}), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_owner = 1'b1;
        exp_rdata  = 8'h00;
        @(posedge clk); @(negedge clk);
        check_val("abort_no_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        check_val("abort_idle", 32'(busy), 32'd0);
        $display("reset during write access to 0x10");
        set_req(1, 1'b0, 8'h10, 8'h00);
        run_access();
        check_val("abort_not_written", 32'(rdata), 32'h11);

        // Randomized traffic; first rounds keep both ports requesting to exercise tie resolution
        for (int r = 0; r < 160; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && (r < 8 || $urandom_range(0, 9) < 5)) begin
                    set_req(p, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)));
                end
            end
            if (pend[0] || pend[1]) run_access();
            else idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
